// File: rtl/seg_message_display.sv
`default_nettype none
// ============================================================================
// Module      : seg_message_display
// Description : Queued HIT/FAIL/SUNK message display with a multiplexed
//               7-segment scan. Optional blink: define SEG_MESSAGE_BLINK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_message_display #(
    parameter int NUM_DIGITS  = 4,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int REFRESH_DIV = 65536,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  msg_valid,
    input  logic [2:0]            msg_code,
    input  logic                  clear,
    output logic                  msg_ready,
    output logic                  busy,
    output logic                  overflow,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES);
    localparam int DIV_W  = $clog2(REFRESH_DIV);
    localparam int DIG_W  = $clog2(NUM_DIGITS);
    localparam int PTR_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W  = $clog2(QUEUE_DEPTH + 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SHOW = 1'b1
    } state_t;

    state_t             r_state;
    logic [HOLD_W-1:0]  r_hold;
    logic [2:0]         r_msg;
    logic [2:0]         r_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]   r_rd;
    logic [PTR_W-1:0]   r_wr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;
    logic [DIV_W-1:0]   r_div;
    logic [DIG_W-1:0]   r_digit;
    logic [DIG_W-1:0]   r_cur;
    logic [6:0]         r_seg;
    logic [NUM_DIGITS-1:0] r_an;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_tick;
    logic [DIG_W-1:0]   w_seg_digit;
    logic [DIG_W:0]     w_char;
    logic [6:0]         w_seg_next;

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Character ch (0 = leftmost) of message code; unknown codes are blank.
    function automatic logic [6:0] f_glyph(input logic [2:0] code, input logic [1:0] ch);
        logic [6:0] g;
        g = SEG_BLANK;
        case ({code, ch})
            5'b001_00: g = 7'b0001001;
            5'b001_01: g = 7'b1111001;
            5'b001_10: g = 7'b0000111;
            5'b010_00: g = 7'b0001110;
            5'b010_01: g = 7'b0001000;
            5'b010_10: g = 7'b1111001;
            5'b010_11: g = 7'b1000111;
            5'b011_00: g = 7'b0010010;
            5'b011_01: g = 7'b1000001;
            5'b011_10: g = 7'b1001000;
            5'b011_11: g = 7'b0001010;
            default:   g = SEG_BLANK;
        endcase
        return g;
    endfunction

    assign w_full    = (r_count == CNT_W'(QUEUE_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = msg_valid && !w_full && !clear;
    assign w_pop     = !clear && !w_empty && ((r_state == S_IDLE) || (r_hold == '0));
    assign msg_ready = !w_full;
    assign busy      = (r_state == S_SHOW) || !w_empty;
    assign overflow  = r_overflow;
    assign seg       = r_seg;
    assign an        = r_an;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= msg_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr <= f_inc(r_wr);
            end
            if (w_pop) begin
                r_rd <= f_inc(r_rd);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (msg_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
            r_msg   <= '0;
        end else if (clear) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
            r_msg   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state <= S_SHOW;
                        r_hold  <= HOLD_W'(HOLD_CYCLES - 1);
                        r_msg   <= r_mem[r_rd];
                    end
                end
                S_SHOW: begin
                    if (r_hold != '0) begin
                        r_hold <= r_hold - HOLD_W'(1);
                    end else if (w_pop) begin
                        r_hold <= HOLD_W'(HOLD_CYCLES - 1);
                        r_msg  <= r_mem[r_rd];
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_hold  <= '0;
                end
            endcase
        end
    end

    assign w_tick = (r_div == DIV_W'(REFRESH_DIV - 1));

    // an is loaded with the current index before it advances, so the first
    // scan step after reset enables the rightmost digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_digit <= '0;
            r_cur   <= '0;
            r_an    <= '1;
        end else begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            if (w_tick) begin
                r_digit <= (r_digit == DIG_W'(NUM_DIGITS - 1)) ? '0 : r_digit + DIG_W'(1);
                r_cur   <= r_digit;
                r_an    <= ~(NUM_DIGITS'(1) << r_digit);
            end
        end
    end

    assign w_seg_digit = w_tick ? r_digit : r_cur;
    assign w_char      = (DIG_W + 1)'(NUM_DIGITS - 1) - {1'b0, w_seg_digit};

`ifdef SEG_MESSAGE_BLINK_EN
    logic w_blink;
    assign w_blink = (r_hold < HOLD_W'(HOLD_CYCLES / 4)) &&
                     (((r_hold >> 3) & HOLD_W'(1)) != '0);
`endif

    always_comb begin
        w_seg_next = SEG_BLANK;
        if ((r_state == S_SHOW) && (w_char < (DIG_W + 1)'(4))) begin
            w_seg_next = f_glyph(r_msg, w_char[1:0]);
`ifdef SEG_MESSAGE_BLINK_EN
            if (w_blink) begin
                w_seg_next = SEG_BLANK;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_BLANK;
        end else if (clear) begin
            r_seg <= SEG_BLANK;
        end else begin
            r_seg <= w_seg_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_message_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_message_display
// Description : Scoreboard bench for seg_message_display (small parameters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_message_display;

    localparam int ND   = 4;
    localparam int HOLD = 10;
    localparam int DIV  = 4;
    localparam int QD   = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          msg_valid = 1'b0;
    logic [2:0]    msg_code = 3'd0;
    logic          clear = 1'b0;
    logic          msg_ready;
    logic          busy;
    logic          overflow;
    logic [6:0]    seg;
    logic [ND-1:0] an;

    typedef struct {
        logic [2:0] code;
        int         start;
        int         stop;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    logic cur_valid = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   blank_seen = 0;
    int   blank_exp = 0;

    seg_message_display #(
        .NUM_DIGITS (ND),
        .HOLD_CYCLES(HOLD),
        .REFRESH_DIV(DIV),
        .QUEUE_DEPTH(QD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .msg_valid(msg_valid),
        .msg_code (msg_code),
        .clear    (clear),
        .msg_ready(msg_ready),
        .busy     (busy),
        .overflow (overflow),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    // Hand-written glyph table: digit d shows character 3-d of the message.
    function automatic logic [6:0] glyph(input logic [2:0] code, input int d);
        logic [6:0] t [4];
        case (code)
            3'd1:    t = '{7'h09, 7'h79, 7'h07, 7'h7F};
            3'd2:    t = '{7'h0E, 7'h08, 7'h79, 7'h47};
            3'd3:    t = '{7'h12, 7'h41, 7'h48, 7'h0A};
            default: t = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};
        endcase
        return t[3 - d];
    endfunction

    // Monitor: scan position follows from the edge count since reset.
    always @(negedge clk) begin
        int k;
        int d;
        int cnt;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        if (!rst_n) begin
            cur_valid = 1'b0;
        end else begin
            k = cyc;
            if (sb.size() > 0 && sb[0].start == k) begin
                cur = sb.pop_front();
                cur_valid = 1'b1;
            end
            if (k < 4) begin
                exp_an = 4'hF;
                d = 0;
            end else begin
                d = ((k / 4) - 1) % 4;
                exp_an = ~(4'b0001 << d);
            end
            check("an_scan", 32'(an), 32'(exp_an));
            exp_seg = 7'h7F;
            if (cur_valid && k <= cur.stop) begin
                exp_seg = glyph(cur.code, d);
                cnt = HOLD - 1 - (k - cur.start);
                if (cnt < HOLD / 4 && exp_seg != 7'h7F) begin
`ifdef SEG_MESSAGE_BLINK_EN
                    if (((cnt >> 3) & 1) == 1) begin
                        exp_seg = 7'h7F;
                        blank_exp++;
                    end
`endif
                    if (seg == 7'h7F) blank_seen++;
                end
            end
            check("seg_display", 32'(seg), 32'(exp_seg));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] code, output int acc);
        msg_valid = 1'b1;
        msg_code  = code;
        @(posedge clk);
        #1;
        msg_valid = 1'b0;
        acc = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int b;
        logic [3:0] an_steps [4];
        an_steps = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        #1 rst_n = 1'b0;
        #1;
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an", 32'(an), 32'hF);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(msg_ready), 32'd1);
        check("rst_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(2);

        // Single HIT from idle: visible two edges after acceptance, for HOLD cycles.
        check("idle_ready", 32'(msg_ready), 32'd1);
        send(3'd1, a);
        sb.push_back('{3'd1, a + 2, a + 11});
        tick(3);
        check("single_busy", 32'(busy), 32'd1);
        tick(10);
        check("single_done_busy", 32'(busy), 32'd0);
        check("single_done_seg", 32'(seg), 32'h7F);

        // Back-to-back HIT, FAIL, SUNK with no gap between holds.
        send(3'd1, a);
        send(3'd2, b);
        send(3'd3, b);
        sb.push_back('{3'd1, a + 2,  a + 11});
        sb.push_back('{3'd2, a + 12, a + 21});
        sb.push_back('{3'd3, a + 22, a + 31});
        tick(35);
        check("b2b_busy", 32'(busy), 32'd0);

        // Overfill while showing: 4th offer rejected, overflow sticky.
        send(3'd1, a);
        sb.push_back('{3'd1, a + 2, a + 11});
        tick(2);
        send(3'd2, b);
        send(3'd3, b);
        check("full_ready", 32'(msg_ready), 32'd0);
        send(3'd1, b);
        check("ovf_set", 32'(overflow), 32'd1);
        sb.push_back('{3'd2, a + 12, a + 21});
        sb.push_back('{3'd3, a + 22, a + 31});
        tick(35);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_busy", 32'(busy), 32'd0);

        // Clear mid-show with a queued entry and a simultaneous push.
        send(3'd1, a);
        sb.push_back('{3'd1, a + 2, a + 4});
        send(3'd2, b);
        tick(3);
        clear     = 1'b1;
        msg_valid = 1'b1;
        msg_code  = 3'd3;
        @(posedge clk);
        #1;
        clear     = 1'b0;
        msg_valid = 1'b0;
        check("clr_seg", 32'(seg), 32'h7F);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_ovf", 32'(overflow), 32'd0);
        check("clr_ready", 32'(msg_ready), 32'd1);
        tick(15);
        check("clr_after_busy", 32'(busy), 32'd0);

        // Unknown code: blank for a full hold while busy.
        send(3'd5, a);
        sb.push_back('{3'd5, a + 2, a + 11});
        tick(5);
        check("unk_busy", 32'(busy), 32'd1);
        tick(10);
        check("unk_done", 32'(busy), 32'd0);

        // Reset mid-show with a queued entry.
        send(3'd3, a);
        send(3'd2, b);
        sb.push_back('{3'd3, a + 2, a + 11});
        tick(4);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_seg", 32'(seg), 32'h7F);
        check("mid_rst_an", 32'(an), 32'hF);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(msg_ready), 32'd1);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(4);
            check("rst_an_step", 32'(an), 32'(an_steps[i]));
        end
        tick(10);
        check("rst_discard_busy", 32'(busy), 32'd0);

        check("blink_count", 32'(blank_seen), 32'(blank_exp));
        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_message_display.md
SEG_MESSAGE_DISPLAY -- requirements
Module: seg_message_display

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits; legal range 4..8.
REQ-002 Parameter HOLD_CYCLES, default 50_000_000: clk cycles each message stays on display; legal minimum 2.
REQ-003 Parameter REFRESH_DIV, default 65536: clk cycles per digit scan step; legal minimum 2.
REQ-004 Parameter QUEUE_DEPTH, default 4: message FIFO entries; legal minimum 1.
REQ-005 Port clk, input, 1: the single clock; all state on rising edge.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port msg_valid, input, 1: message offer; accepted on an edge where msg_valid && msg_ready.
REQ-008 Port msg_code, input, 3: 1=HIT, 2=FAIL, 3=SUNK; other values display blank for a full hold.
REQ-009 Port clear, input, 1: synchronous flush of queue, display and overflow flag.
REQ-010 Port msg_ready, output, 1: high when the FIFO is not full.
REQ-011 Port busy, output, 1: high in SHOW state or with a non-empty FIFO.
REQ-012 Port overflow, output, 1: sticky; set when msg_valid && !msg_ready.
REQ-013 Port seg, output, 7: active-low segments, bit6..0 = g..a, registered.
REQ-014 Port an, output, NUM_DIGITS: active-low digit enables, one-hot-low, registered; an[0] = rightmost digit.

Function
REQ-015 The block SHALL implement two states: IDLE (seg all ones) and SHOW (current message).
REQ-016 IDLE with non-empty FIFO SHALL pop the head and enter SHOW on the next edge.
REQ-017 A message accepted into an empty FIFO in IDLE SHALL appear on seg exactly 2 edges after the acceptance edge.
REQ-018 SHOW SHALL last exactly HOLD_CYCLES cycles via a down-counter loaded on entry.
REQ-019 At hold expiry, a non-empty FIFO SHALL pop the next message and re-enter SHOW with no blank cycle; otherwise the block SHALL go to IDLE.
REQ-020 Push and pop on the same edge SHALL both take effect; occupancy is unchanged.
REQ-021 The scan divider SHALL advance the digit index every REFRESH_DIV cycles, wrapping NUM_DIGITS-1 -> 0, in both states.
REQ-022 Text SHALL be left-aligned: character i (0..3) on digit NUM_DIGITS-1-i; remaining digits blank.
REQ-023 Glyphs: H 0001001, I 1111001, t 0000111, F 0001110, A 0001000, L 1000111, S 0010010, U 1000001, N 1001000, K 0001010.
REQ-024 Messages SHALL read HIT_ (last character blank), FAIL and SUNK.
REQ-025 clear SHALL empty the FIFO, force IDLE, zero the hold counter and clear overflow on the next edge.
REQ-026 clear SHALL take priority over a same-cycle push; that push is dropped and does not set overflow.
REQ-027 A rejected offer SHALL leave FIFO contents and the current display unchanged.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, empty FIFO, counters 0, digit index 0, seg=7'h7F, an all ones, overflow=0, busy=0, msg_ready=1.
REQ-029 Reset mid-SHOW SHALL discard the current and queued messages; the first scan step after release drives an[0] low.

Configuration
REQ-030 With macro SEG_MESSAGE_BLINK_EN defined, seg SHALL be forced to all ones during the final quarter of each hold (hold counter < HOLD_CYCLES/4) on cycles where hold counter bit 3 is 1.
REQ-031 Without SEG_MESSAGE_BLINK_EN, seg SHALL show the message steadily for the full hold and no blink logic SHALL be built.

Verification (HOLD_CYCLES=10, REFRESH_DIV=4, QUEUE_DEPTH=2, NUM_DIGITS=4)
REQ-032 Push code 1 when idle -> seg shows H on an=0111 from edge +2 for 10 cycles, then seg=7F and busy=0.
REQ-033 Push 1, 2, 3 back-to-back -> HIT then FAIL then SUNK, each for 10 cycles, with no blank cycle between them.
REQ-034 Push 4 messages while the first is shown -> 4th offer sees msg_ready=0, overflow=1, and exactly 3 messages are shown.
REQ-035 Assert clear mid-SHOW with a queued entry and a same-cycle push -> next edge: IDLE, seg=7F, busy=0, overflow=0.
REQ-036 Assert rst_n low mid-SHOW for 1 cycle -> outputs take reset values immediately; after release, an steps 1110, 1101, 1011, 0111 at 4-cycle intervals.
REQ-037 Test with blink macro on and off -> cycle count with seg=7F during the final quarter of each hold matches REQ-030/031.
